step_seq_ctrl: RTL and testbench

// - Run-length controller driving the 4-bit synchronous step counter: drives its clr/en and reads back q/is_all_zero.
// - On start, clears the counter and steps it 0..len_r, optionally stalled by hold. Emits a per-step strobe and index.
// - Ends with a one-cycle done pulse. Sits between the top-level control FSM and the counter instance.

---
 rtl/step_seq_ctrl_if.sv | 35 +++
 rtl/step_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_step_seq_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/step_seq_ctrl_if.sv
// Control/status bundle between the top-level control FSM, the run-length
// controller and the 4-bit step counter.
//   start/len/hold/abort : run request and control from the top-level FSM
//   cnt_q/cnt_zero       : counter read-back (q, is_all_zero)
//   cnt_en/cnt_clr       : counter drive
//   step/step_vld        : per-step index and strobe
//   busy/done/fault      : run status
// slave  = controller side, master = environment side.
interface step_seq_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             hold;
  logic             abort;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_zero;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] step;
  logic             step_vld;
  logic             busy;
  logic             done;
  logic             fault;

  modport slave (
    input  start, len, hold, abort, cnt_q, cnt_zero,
    output cnt_en, cnt_clr, step, step_vld, busy, done, fault
  );

  modport master (
    output start, len, hold, abort, cnt_q, cnt_zero,
    input  cnt_en, cnt_clr, step, step_vld, busy, done, fault
  );
endinterface

// File: rtl/step_seq_ctrl.sv
// Run-length controller for the 4-bit step counter. On start it clears the
// counter, then steps it 0..len_r (stalled by hold), issuing one step_vld
// strobe per completed step and a one-cycle done pulse at the end. Detects
// counter wrap and excessive consecutive hold as a sticky fault.
// Ports:
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset (also clears the counter via cnt_clr)
//   sif   : control/status bundle (slave modport), see step_seq_ctrl_if
module step_seq_ctrl #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  step_seq_ctrl_if.slave  sif
);

  localparam int unsigned SW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_r_q, len_r_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             fault_q, fault_d;
  logic             seen_nz_q, seen_nz_d;
  logic             abort_clr_q, abort_clr_d;

  logic [SW-1:0]    stall_inc;
  logic             fsm_clr;
  logic             cnt_en_c;
  logic [CNT_W-1:0] step_c;
  logic             step_vld_c;
  logic             busy_c;
  logic             done_c;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      len_r_q     <= '0;
      stall_cnt_q <= '0;
      fault_q     <= 1'b0;
      seen_nz_q   <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_r_q     <= len_r_d;
      stall_cnt_q <= stall_cnt_d;
      fault_q     <= fault_d;
      seen_nz_q   <= seen_nz_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_r_d     = len_r_q;
    stall_cnt_d = '0;
    fault_d     = fault_q;
    seen_nz_d   = seen_nz_q;
    abort_clr_d = 1'b0;
    fsm_clr     = 1'b0;
    cnt_en_c    = 1'b0;
    step_c      = '0;
    step_vld_c  = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;

    // Saturating increment of the consecutive-hold counter.
    stall_inc = (stall_cnt_q == SW'(MAX_HOLD)) ? stall_cnt_q : stall_cnt_q + SW'(1);

    unique case (state_q)
      S_IDLE: begin
        seen_nz_d = 1'b0;
        if (sif.start && !sif.abort) begin
          state_d = S_CLEAR;
          len_r_d = sif.len;
          fault_d = 1'b0;
        end
      end
      S_CLEAR: begin
        busy_c    = 1'b1;
        fsm_clr   = 1'b1;
        seen_nz_d = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        busy_c     = 1'b1;
        step_c     = sif.cnt_q;
        step_vld_c = !sif.hold;
        // Counter is never enabled past len_r, so it parks on the last index.
        cnt_en_c   = !sif.hold && (sif.cnt_q != len_r_q);
        if (sif.cnt_q != '0) seen_nz_d = 1'b1;
        if (sif.hold) stall_cnt_d = stall_inc;
        // A zero count after having left zero means the counter wrapped.
        if ((sif.cnt_zero && seen_nz_q) ||
            (sif.hold && (stall_inc >= SW'(MAX_HOLD)))) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else if (!sif.hold && (sif.cnt_q == len_r_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        fsm_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the state-specific decisions above: no step, no done,
    // no new fault; the counter clear is issued one cycle later from a flop.
    if (sif.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      abort_clr_d = 1'b1;
      fault_d     = fault_q;
      stall_cnt_d = '0;
      cnt_en_c    = 1'b0;
      step_vld_c  = 1'b0;
      done_c      = 1'b0;
    end
  end

  // ~clr_n term clears the counter while this block is held in reset.
  assign sif.cnt_clr  = !clr_n || fsm_clr || abort_clr_q;
  assign sif.cnt_en   = cnt_en_c;
  assign sif.step     = step_c;
  assign sif.step_vld = step_vld_c;
  assign sif.busy     = busy_c;
  assign sif.done     = done_c;
  assign sif.fault    = fault_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
module tb_step_seq_ctrl;

  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic clr_n;
  logic [3:0] cnt = '0;
  logic force_zero = 1'b0;

  int n_err = 0;
  int n_checks = 0;
  logic last_fault = 1'b0;

  step_seq_ctrl_if #(.CNT_W(4)) sif ();

  step_seq_ctrl #(.CNT_W(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit synchronous step counter driven by the controller.
  always @(posedge clk) begin
    if (sif.cnt_clr) cnt <= '0;
    else if (sif.cnt_en) cnt <= cnt + 4'd1;
  end
  assign sif.cnt_q    = cnt;
  assign sif.cnt_zero = (cnt == 4'd0) || force_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One run of length l. Model: step index advances by one on every non-hold
  // RUN cycle; strobes 0..l; done in the cycle after the last strobe.
  // mode: 0 no hold, 1 random hold/start/len noise, 2 hold h_n cycles at step h_step
  // ev_kind: 0 none, 1 abort, 2 force cnt_zero, 3 reset; fired at step ev_step
  task automatic run_seq(input int l, input int mode, input int h_step, input int h_n,
                         input int ev_step, input int ev_kind);
    int   idx = 0;
    int   hleft = h_n;
    int   consec = 0;
    int   guard = 0;
    bit   h;
    bit   ev;
    bit   hit = 0;
    bit   stop = 0;
    logic fault_exp = 1'b0;

    @(negedge clk);
    sif.start = 1'b1; sif.len = l[3:0]; sif.abort = 1'b0;
    sif.hold = 1'($urandom_range(0, 1));
    #1;
    chk("idle_busy", sif.busy, 0);
    chk("idle_done", sif.done, 0);
    chk("idle_clr", sif.cnt_clr, 0);
    chk("idle_fault", sif.fault, last_fault);

    @(negedge clk);
    sif.start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    sif.len   = 4'($urandom);
    sif.hold  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("clear_clr", sif.cnt_clr, 1);
    chk("clear_busy", sif.busy, 1);
    chk("clear_vld", sif.step_vld, 0);
    chk("clear_en", sif.cnt_en, 0);
    chk("clear_fault", sif.fault, 0);

    while (!stop) begin
      @(negedge clk);
      guard++;
      h = 1'b0;
      if (mode == 1) h = (consec < 3) && ($urandom_range(0, 2) == 0);
      else if (mode == 2 && idx == h_step && hleft > 0) begin
        h = 1'b1;
        hleft--;
      end
      consec = h ? consec + 1 : 0;
      sif.hold  = h;
      sif.start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      sif.len   = 4'($urandom);
      ev = (ev_kind != 0) && (idx == ev_step) && !hit;
      if (ev) begin
        hit = 1'b1;
        if (ev_kind == 1) sif.abort = 1'b1;
        else if (ev_kind == 2) force_zero = 1'b1;
        else clr_n = 1'b0;
      end
      #1;
      if (ev && ev_kind == 3) begin
        chk("rst_clr", sif.cnt_clr, 1);
        chk("rst_busy", sif.busy, 0);
        chk("rst_vld", sif.step_vld, 0);
        chk("rst_step", sif.step, 0);
        chk("rst_en", sif.cnt_en, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_fault", sif.fault, 0);
        stop = 1;
      end else if (ev && ev_kind == 1) begin
        chk("abort_vld", sif.step_vld, 0);
        chk("abort_en", sif.cnt_en, 0);
        chk("abort_done", sif.done, 0);
        stop = 1;
      end else begin
        chk("run_step", sif.step, idx);
        chk("run_vld", sif.step_vld, !h);
        chk("run_en", sif.cnt_en, (!h && idx != l));
        chk("run_busy", sif.busy, 1);
        chk("run_done", sif.done, 0);
        chk("run_clr", sif.cnt_clr, 0);
        chk("cnt_le_len", (int'(cnt) <= l), 1);
        if (consec == int'(MAX_HOLD) || (ev && ev_kind == 2)) begin
          fault_exp = 1'b1;
          stop = 1;
        end
        if (!h) begin
          if (idx == l) stop = 1;
          idx++;
        end
      end
      chk("run_budget", (guard > 100), 0);
      if (guard > 100) stop = 1;
    end

    if (ev_kind == 1 && hit) begin
      @(negedge clk);
      sif.abort = 1'b0; sif.start = 1'b0; sif.hold = 1'b0;
      #1;
      chk("post_abort_busy", sif.busy, 0);
      chk("post_abort_done", sif.done, 0);
      chk("post_abort_clr", sif.cnt_clr, 1);
      @(negedge clk);
      #1;
      chk("post_abort_cnt", cnt, 0);
      chk("post_abort_clr2", sif.cnt_clr, 0);
      chk("post_abort_done2", sif.done, 0);
      last_fault = 1'b0;
    end else if (ev_kind == 3 && hit) begin
      @(negedge clk);
      chk("rst_cnt", cnt, 0);
      clr_n = 1'b1; sif.start = 1'b0; sif.hold = 1'b0;
      #1;
      chk("rst_rel_busy", sif.busy, 0);
      chk("rst_rel_clr", sif.cnt_clr, 0);
      chk("rst_rel_fault", sif.fault, 0);
      last_fault = 1'b0;
    end else begin
      @(negedge clk);
      force_zero = 1'b0;
      sif.hold  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      sif.start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("done_pulse", sif.done, 1);
      chk("done_busy", sif.busy, 0);
      chk("done_clr", sif.cnt_clr, 1);
      chk("done_fault", sif.fault, fault_exp);
      chk("done_vld", sif.step_vld, 0);
      chk("done_en", sif.cnt_en, 0);
      @(negedge clk);
      sif.start = 1'b0; sif.hold = 1'b0;
      #1;
      chk("after_done", sif.done, 0);
      chk("after_busy", sif.busy, 0);
      chk("after_fault", sif.fault, fault_exp);
      last_fault = fault_exp;
    end
  endtask

  initial begin
    clr_n = 1'b0;
    sif.start = 1'b0; sif.len = '0; sif.hold = 1'b0; sif.abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_clr", sif.cnt_clr, 1);
    chk("reset_busy", sif.busy, 0);
    chk("reset_done", sif.done, 0);
    chk("reset_vld", sif.step_vld, 0);
    chk("reset_fault", sif.fault, 0);
    chk("reset_en", sif.cnt_en, 0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("release_clr", sif.cnt_clr, 0);

    run_seq(3, 0, 0, 0, 0, 0);
    run_seq(5, 2, 2, 2, 0, 0);
    run_seq(0, 0, 0, 0, 0, 0);
    run_seq(15, 0, 0, 0, 0, 0);
    run_seq(7, 0, 0, 0, 1, 1);
    run_seq(2, 0, 0, 0, 0, 0);
    run_seq(7, 0, 0, 0, 4, 2);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("fault_sticky", sif.fault, 1);
    end
    run_seq(5, 2, 2, MAX_HOLD, 0, 0);
    run_seq(5, 2, 2, MAX_HOLD - 1, 0, 0);
    run_seq(7, 0, 0, 0, 3, 3);
    for (int unsigned i = 0; i < 8; i++) begin
      run_seq(int'($urandom_range(0, 15)), 1, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
